except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl.sv | 179 +++++++++++++++++
 tb/tb_except_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// Exception / interrupt controller: picks the oldest excepting lane (or a pending
// interrupt), raises a single held request to CP0, then pulses a pipeline flush.
module except_ctrl #(
    parameter int unsigned N_ISSUE      = 2,
    parameter int unsigned N_INT        = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [N_ISSUE-1:0]                            inst_valid,
    input  logic [N_ISSUE-1:0]                            exc_valid,
    input  logic [N_ISSUE-1:0]                            exc_eret,
    input  logic [5*N_ISSUE-1:0]                          exc_code,
    input  logic [32*N_ISSUE-1:0]                         exc_pc,
    input  logic [N_ISSUE-1:0]                            exc_delayslot,
    input  logic [N_ISSUE-1:0]                            exc_tlb_refill,
    input  logic [N_INT-1:0]                              int_raw,
    input  logic                                          status_ie,
    input  logic                                          status_exl,
    input  logic                                          status_erl,
    input  logic                                          status_bev,
    input  logic                                          cause_iv,
    input  logic [31:0]                                   epc,
    input  logic [31:0]                                   error_epc,
    input  logic [31:0]                                   ebase,
    output logic                                          req_valid,
    input  logic                                          req_ack,
    output logic [4:0]                                    req_code,
    output logic [31:0]                                   req_pc,
    output logic                                          req_delayslot,
    output logic                                          req_eret,
    output logic [((N_ISSUE > 1) ? $clog2(N_ISSUE) : 1)-1:0] req_lane,
    output logic [31:0]                                   req_vec,
    output logic                                          flush,
    output logic                                          busy,
    output logic [N_INT-1:0]                              int_pending
);

    localparam int unsigned LaneW = (N_ISSUE > 1) ? $clog2(N_ISSUE) : 1;
    localparam int unsigned CntW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [N_INT-1:0]    sync_q [SYNC_STAGES];

    logic                win_valid;
    logic [4:0]          win_code;
    logic [31:0]         win_pc;
    logic                win_ds;
    logic                win_refill;
    logic                win_eret;
    logic [LaneW-1:0]    win_lane;
    logic [31:0]         win_vec;
    logic [11:0]         vec_off;
    logic                int_take;

    // Only the page-aligned part of EBASE forms the vector.
    logic unused_ebase;
    assign unused_ebase = ^ebase[11:0];

    // Interrupt synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= int_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign int_pending = sync_q[SYNC_STAGES-1];
    assign int_take    = status_ie & ~status_exl & ~status_erl & (|int_pending) & (|inst_valid);

    // Winner selection: interrupt first, else lowest-index excepting lane.
    always_comb begin
        win_valid  = 1'b0;
        win_code   = '0;
        win_pc     = '0;
        win_ds     = 1'b0;
        win_refill = 1'b0;
        win_eret   = 1'b0;
        win_lane   = '0;
        if (int_take) begin
            win_valid = 1'b1;
            // Descending scan so the lowest valid lane is assigned last.
            for (int i = int'(N_ISSUE) - 1; i >= 0; i--) begin
                if (inst_valid[i]) begin
                    win_pc   = exc_pc[32*i +: 32];
                    win_ds   = exc_delayslot[i];
                    win_lane = LaneW'(i);
                end
            end
        end else begin
            for (int i = int'(N_ISSUE) - 1; i >= 0; i--) begin
                if (exc_valid[i] | exc_eret[i]) begin
                    win_valid  = 1'b1;
                    win_code   = exc_code[5*i +: 5];
                    win_pc     = exc_pc[32*i +: 32];
                    win_ds     = exc_delayslot[i];
                    win_refill = exc_tlb_refill[i];
                    win_eret   = exc_eret[i];
                    win_lane   = LaneW'(i);
                end
            end
        end
    end

    // Redirect target from the CP0 state of the capture cycle.
    always_comb begin
        vec_off = 12'h180;
        if (!status_exl && win_refill && (win_code == 5'd2 || win_code == 5'd3)) begin
            vec_off = 12'h000;
        end else if (!status_exl && win_code == 5'd0 && cause_iv) begin
            vec_off = 12'h200;
        end
        if (win_eret) begin
            win_vec = status_erl ? error_epc : epc;
        end else if (status_bev) begin
            win_vec = 32'hBFC0_0200 + {20'd0, vec_off};
        end else begin
            win_vec = {ebase[31:12], vec_off};
        end
    end

    // Control FSM with registered request, flush and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_valid     <= 1'b0;
            req_code      <= '0;
            req_pc        <= '0;
            req_delayslot <= 1'b0;
            req_eret      <= 1'b0;
            req_lane      <= '0;
            req_vec       <= '0;
            flush         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q       <= StReq;
                        req_valid     <= 1'b1;
                        busy          <= 1'b1;
                        req_code      <= win_code;
                        req_pc        <= win_pc;
                        req_delayslot <= win_ds;
                        req_eret      <= win_eret;
                        req_lane      <= win_lane;
                        req_vec       <= win_vec;
                    end
                end
                StReq: begin
                    if (req_ack) begin
                        state_q   <= StFlush;
                        req_valid <= 1'b0;
                        flush     <= 1'b1;
                        cnt_q     <= CntW'(FLUSH_CYCLES - 1);
                    end
                end
                StFlush: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        flush   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Randomised + directed bench for except_ctrl with a behavioural reference model.
module tb_except_ctrl;

    localparam int NI = 2;
    localparam int NT = 8;
    localparam int SS = 2;
    localparam int FC = 2;
    localparam int LW = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   inst_valid, exc_valid, exc_eret, exc_delayslot, exc_tlb_refill;
    logic [5*NI-1:0] exc_code;
    logic [32*NI-1:0] exc_pc;
    logic [NT-1:0]   int_raw;
    logic            status_ie, status_exl, status_erl, status_bev, cause_iv;
    logic [31:0]     epc, error_epc, ebase;
    logic            req_valid, req_ack, req_delayslot, req_eret, flush, busy;
    logic [4:0]      req_code;
    logic [31:0]     req_pc, req_vec;
    logic [LW-1:0]   req_lane;
    logic [NT-1:0]   int_pending;

    except_ctrl #(
        .N_ISSUE(NI), .N_INT(NT), .SYNC_STAGES(SS), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .exc_valid(exc_valid),
        .exc_eret(exc_eret), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_delayslot(exc_delayslot), .exc_tlb_refill(exc_tlb_refill), .int_raw(int_raw),
        .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
        .status_bev(status_bev), .cause_iv(cause_iv), .epc(epc), .error_epc(error_epc),
        .ebase(ebase), .req_valid(req_valid), .req_ack(req_ack), .req_code(req_code),
        .req_pc(req_pc), .req_delayslot(req_delayslot), .req_eret(req_eret),
        .req_lane(req_lane), .req_vec(req_vec), .flush(flush), .busy(busy),
        .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an outstanding request, a count of flush cycles still to show,
    // and the history of sampled interrupt lines.
    bit             m_reqv;
    int             m_fl;
    logic [4:0]     m_code;
    logic [31:0]    m_pc, m_vec;
    bit             m_ds, m_eret;
    int             m_lane;
    logic [NT-1:0]  m_pend;
    logic [NT-1:0]  hist[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] vec_of(bit eret, logic [4:0] code, bit refill);
        logic [31:0] off;
        if (eret) return status_erl ? error_epc : epc;
        if (!status_exl && refill && (code == 2 || code == 3)) off = 0;
        else if (!status_exl && code == 0 && cause_iv) off = 32'h200;
        else off = 32'h180;
        if (status_bev) return 32'hBFC00200 + off;
        return (ebase & 32'hFFFFF000) | off;
    endfunction

    task automatic model_reset();
        m_reqv = 0; m_fl = 0; m_code = 0; m_pc = 0; m_vec = 0;
        m_ds = 0; m_eret = 0; m_lane = 0; m_pend = 0;
        hist.delete();
    endtask

    // Advance the model over one clock edge using the inputs present at that edge.
    task automatic model_step();
        int lane = -1;
        if (m_reqv) begin
            if (req_ack) begin m_reqv = 0; m_fl = FC; end
        end else if (m_fl > 0) begin
            m_fl--;
        end else if (status_ie && !status_exl && !status_erl && m_pend != 0 && inst_valid != 0) begin
            for (int i = 0; i < NI; i++) if (inst_valid[i] && lane < 0) lane = i;
            m_reqv = 1; m_code = 0; m_pc = exc_pc[32*lane +: 32];
            m_ds = exc_delayslot[lane]; m_eret = 0; m_lane = lane; m_vec = vec_of(0, 5'd0, 0);
        end else begin
            for (int i = 0; i < NI; i++) if ((exc_valid[i] || exc_eret[i]) && lane < 0) lane = i;
            if (lane >= 0) begin
                m_reqv = 1; m_code = exc_code[5*lane +: 5]; m_pc = exc_pc[32*lane +: 32];
                m_ds = exc_delayslot[lane]; m_eret = exc_eret[lane]; m_lane = lane;
                m_vec = vec_of(exc_eret[lane], exc_code[5*lane +: 5], exc_tlb_refill[lane]);
            end
        end
        hist.push_front(int_raw);
        if (hist.size() > SS) void'(hist.pop_back());
        m_pend = (hist.size() == SS) ? hist[SS-1] : '0;
    endtask

    task automatic compare_all();
        chk("req_valid", 32'(req_valid), 32'(m_reqv));
        chk("flush", 32'(flush), 32'(m_fl > 0));
        chk("busy", 32'(busy), 32'(m_reqv || m_fl > 0));
        chk("req_code", 32'(req_code), 32'(m_code));
        chk("req_pc", req_pc, m_pc);
        chk("req_ds", 32'(req_delayslot), 32'(m_ds));
        chk("req_eret", 32'(req_eret), 32'(m_eret));
        chk("req_lane", 32'(req_lane), 32'(m_lane));
        chk("req_vec", req_vec, m_vec);
        chk("int_pending", 32'(int_pending), 32'(m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr_exc();
        exc_valid = 0; exc_eret = 0; exc_tlb_refill = 0; exc_delayslot = 0;
    endtask

    task automatic clr_in();
        clr_exc();
        inst_valid = 0; exc_code = 0; exc_pc = 0; int_raw = 0; req_ack = 0;
        status_ie = 0; status_exl = 0; status_erl = 0; status_bev = 0; cause_iv = 0;
        epc = 0; error_epc = 0; ebase = 32'h8000_0000;
    endtask

    task automatic drain();
        clr_exc();
        req_ack = 1;
        tick();
        req_ack = 0;
        repeat (FC) tick();
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        rst_n = 1;

        // Lane 1 exception, captured on the first edge after reset release.
        inst_valid = 2'b11; exc_valid = 2'b10;
        exc_code[9:5] = 5'd4; exc_pc[63:32] = 32'h8000_1004;
        tick();
        clr_exc();
        chk("r19_valid", 32'(req_valid), 32'd1);
        chk("r19_lane", 32'(req_lane), 32'd1);
        chk("r19_code", 32'(req_code), 32'd4);
        chk("r19_vec", req_vec, 32'h8000_0180);
        req_ack = 1; tick(); req_ack = 0;
        chk("r19_flush1", 32'(flush), 32'd1);
        tick();
        chk("r19_flush2", 32'(flush), 32'd1);
        tick();
        chk("r19_flush_end", 32'(flush), 32'd0);

        // Two lanes excepting: lane 0 wins.
        exc_valid = 2'b11; exc_code = {5'd4, 5'd10};
        tick();
        chk("r20_lane", 32'(req_lane), 32'd0);
        chk("r20_code", 32'(req_code), 32'd10);
        drain();

        // Interrupt through the synchroniser.
        status_ie = 1; cause_iv = 1; inst_valid = 2'b10; exc_pc[63:32] = 32'h8000_2000;
        int_raw[3] = 1;
        for (int i = 0; i < SS; i++) begin
            tick();
            chk("r21_early", 32'(req_valid), 32'd0);
        end
        tick();
        chk("r21_valid", 32'(req_valid), 32'd1);
        chk("r21_code", 32'(req_code), 32'd0);
        chk("r21_pc", req_pc, 32'h8000_2000);
        chk("r21_vec", req_vec, 32'h8000_0200);
        int_raw = 0; status_ie = 0;
        drain();
        repeat (SS) tick();
        status_ie = 1; status_exl = 1; int_raw[3] = 1;
        repeat (SS + 3) tick();
        chk("r21_exl_none", 32'(req_valid), 32'd0);
        int_raw = 0; status_ie = 0; status_exl = 0;
        repeat (SS) tick();

        // ERET targets.
        inst_valid = 2'b01; exc_eret = 2'b01; status_erl = 1;
        error_epc = 32'hBFC0_0380; epc = 32'h8000_4000;
        tick();
        chk("r22_eret", 32'(req_eret), 32'd1);
        chk("r22_vec_erl", req_vec, 32'hBFC0_0380);
        drain();
        exc_eret = 2'b01; status_erl = 0;
        tick();
        chk("r22_vec_epc", req_vec, 32'h8000_4000);
        drain();

        // TLB refill vectors under BEV.
        exc_valid = 2'b01; exc_tlb_refill = 2'b01; exc_code[4:0] = 5'd2; status_bev = 1;
        tick();
        chk("r23_vec", req_vec, 32'hBFC0_0200);
        drain();
        exc_valid = 2'b01; exc_tlb_refill = 2'b01; status_exl = 1;
        tick();
        chk("r23_vec_exl", req_vec, 32'hBFC0_0380);
        drain();
        status_exl = 0; status_bev = 0;

        // Withheld ack with exceptions injected during REQ and FLUSH.
        exc_valid = 2'b01; exc_code = {5'd9, 5'd5}; exc_pc = {32'h1111_0000, 32'h8000_5000};
        tick();
        for (int i = 0; i < 5; i++) begin
            exc_valid = 2'b11; exc_code = {5'(i + 12), 5'(i + 20)}; exc_pc = {2{32'($urandom)}};
            tick();
            chk("r24_hold_valid", 32'(req_valid), 32'd1);
            chk("r24_hold_code", 32'(req_code), 32'd5);
            chk("r24_hold_pc", req_pc, 32'h8000_5000);
        end
        req_ack = 1; tick(); req_ack = 0;
        exc_valid = 2'b11;
        repeat (FC) tick();
        chk("r24_no_second", 32'(req_valid), 32'd0);
        clr_exc();
        tick();

        // Reset pulse during FLUSH.
        exc_valid = 2'b01;
        tick();
        clr_exc();
        req_ack = 1; tick(); req_ack = 0;
        chk("r24_in_flush", 32'(flush), 32'd1);
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        chk("r24_rst_flush", 32'(flush), 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("r24_after_rst", 32'(flush), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                inst_valid[i]     = ($urandom_range(0, 3) != 0);
                exc_valid[i]      = ($urandom_range(0, 7) == 0);
                exc_eret[i]       = ($urandom_range(0, 15) == 0);
                exc_delayslot[i]  = 1'($urandom);
                exc_tlb_refill[i] = 1'($urandom);
                exc_code[5*i +: 5] = 5'($urandom_range(0, 5));
                exc_pc[32*i +: 32] = $urandom;
            end
            if ($urandom_range(0, 15) == 0) int_raw[$urandom_range(0, NT - 1)] ^= 1'b1;
            status_ie  = 1'($urandom);
            status_exl = ($urandom_range(0, 3) == 0);
            status_erl = ($urandom_range(0, 7) == 0);
            status_bev = 1'($urandom);
            cause_iv   = 1'($urandom);
            epc = $urandom; error_epc = $urandom; ebase = $urandom;
            req_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
